// File: rtl/pl_rv32_mem_arbiter.sv
// pl_rv32_mem_arbiter
// Shares one single-port memory between the IF fetch port and the MEM-stage
// load/store port. The data side has fixed priority. A starvation limiter
// forces a fetch grant after a bounded run of data grants. One transaction is
// outstanding at a time. Its response is routed back to the owner, and a
// transaction whose response never arrives is aborted after TIMEOUT cycles.
module pl_rv32_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic                clk,
  input  logic                rst,
  // fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  // data port
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_err,
  // memory port
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int WC_W = $clog2(TIMEOUT);
  localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_LIMIT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_t;

  // Saturating increment. The counter parks at STARVE_LIMIT until a fetch grant
  // clears it.
  function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
    return (v == SC_MAX) ? SC_MAX : v + 1'b1;
  endfunction

  state_t            r_state, w_state_nxt;
  owner_t            r_owner, w_owner_nxt;
  logic [SC_W-1:0]   r_starve_cnt, w_starve_nxt;
  logic [WC_W-1:0]   r_wait_cnt, w_wait_nxt;
  logic              w_dm_win;
  logic              w_if_win;
  logic              w_grant;

  // Winner selection: data wins unless fetch has been starved to the limit
  assign w_dm_win = dm_req && !(if_req && (r_starve_cnt == SC_MAX));
  assign w_if_win = !w_dm_win && if_req;
  assign w_grant  = (r_state == S_IDLE) && (w_dm_win || w_if_win) && mem_ready;

  // State, owner and counter registers; cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_IF;
      r_starve_cnt <= '0;
      r_wait_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_wait_cnt   <= w_wait_nxt;
    end
  end

  // Next-state logic and all outputs. Every output is held at zero during reset.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_starve_nxt = r_starve_cnt;
    w_wait_nxt   = r_wait_cnt;
    if_gnt       = 1'b0;
    if_rvalid    = 1'b0;
    if_rdata     = '0;
    if_err       = 1'b0;
    dm_gnt       = 1'b0;
    dm_rvalid    = 1'b0;
    dm_rdata     = '0;
    dm_err       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_be       = '0;

    case (r_state)
      S_IDLE: begin
        // A stray mem_rvalid here is ignored by construction.
        if (w_dm_win) begin
          mem_req   = 1'b1;
          mem_we    = dm_we;
          mem_addr  = dm_addr;
          mem_wdata = dm_wdata;
          mem_be    = dm_be;
          dm_gnt    = mem_ready;
        end else if (w_if_win) begin
          mem_req   = 1'b1;
          mem_addr  = if_addr;
          mem_be    = '1;
          if_gnt    = mem_ready;
        end
        if (w_grant) begin
          w_state_nxt = S_WAIT;
          w_wait_nxt  = '0;
          w_owner_nxt = w_dm_win ? OWN_DM : OWN_IF;
          if (w_dm_win && if_req) w_starve_nxt = sat_inc(r_starve_cnt);
          else                    w_starve_nxt = '0;
        end
      end
      S_WAIT: begin
        w_wait_nxt = r_wait_cnt + 1'b1;
        if (mem_rvalid) begin
          // A response arriving on the timeout cycle still counts as a success.
          if (r_owner == OWN_DM) begin
            dm_rvalid = 1'b1;
            dm_rdata  = mem_rdata;
          end else begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end
          w_state_nxt = S_IDLE;
        end else if (r_wait_cnt == WC_LAST) begin
          if (r_owner == OWN_DM) begin
            dm_rvalid = 1'b1;
            dm_err    = 1'b1;
          end else begin
            if_rvalid = 1'b1;
            if_err    = 1'b1;
          end
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (rst) begin
      if_gnt    = 1'b0;
      if_rvalid = 1'b0;
      if_rdata  = '0;
      if_err    = 1'b0;
      dm_gnt    = 1'b0;
      dm_rvalid = 1'b0;
      dm_rdata  = '0;
      dm_err    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
    end
  end

endmodule

// File: doc/pl_rv32_mem_arbiter.md
Name: pl_rv32_mem_arbiter

Overview:
- Shares one single-port instruction/data memory between the IF-stage fetch requester and the MEM-stage load/store requester.
- Arbitration: data side has fixed priority over fetch; a starvation limiter forces a fetch grant after a bounded run of data grants.
- Sequences one outstanding memory transaction at a time, routes the response back to its owner, and aborts transactions whose response times out.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- STARVE_LIMIT, 4, number of consecutive data grants, while a fetch is pending, before fetch is forced to win (≥1)
- TIMEOUT, 16, cycles spent in WAIT without mem_rvalid before the transaction is aborted (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch response valid, one-cycle pulse
- if_rdata  out  DATA_W  fetch read data
- if_err  out  1  fetch aborted by timeout (qualified by if_rvalid)
- dm_req  in  1  data request; held with dm_* until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_be  in  DATA_W/8  store byte enables
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  load data or store completion, one-cycle pulse
- dm_rdata  out  DATA_W  load data
- dm_err  out  1  data access aborted by timeout (qualified by dm_rvalid)
- mem_req  out  1  request to memory
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  request fields to memory
- mem_ready  in  1  memory accepts the request when mem_req && mem_ready
- mem_rvalid  in  1  memory response (read data, or write completion)
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset:
  - Clock is clk. Reset rst is asynchronous and active-high.
  - While rst is high: state=IDLE, owner=IF, starve_cnt=0, wait_cnt=0.
  - While rst is high, every output is forced to 0, including the combinational ones.
- FSM states: IDLE, WAIT.
- IDLE, winner selection:
  - Winner is DM if dm_req && !(if_req && starve_cnt==STARVE_LIMIT).
  - Otherwise the winner is IF if if_req.
  - Otherwise there is no winner.
- IDLE, memory drive:
  - mem_req = 1 when there is a winner; mem_* carry the winner's fields.
  - For IF: mem_we=0, mem_be=all ones, mem_wdata=0.
- Grant:
  - Fires when mem_req && mem_ready, in the same cycle.
  - The winner's gnt pulses combinationally; the loser gets no gnt.
  - Next cycle: owner ← winner, wait_cnt ← 0, state ← WAIT.
- No grant: if mem_ready is low, stay in IDLE and re-arbitrate every cycle. The winner may change if a higher-priority request appears.
- Starvation counter:
  - On a DM grant with if_req high: starve_cnt ← min(starve_cnt+1, STARVE_LIMIT).
  - On an IF grant: starve_cnt ← 0.
  - On a DM grant with if_req low: starve_cnt ← 0.
- WAIT, idle behaviour: mem_req=0; both gnt=0; wait_cnt increments each cycle.
- WAIT, response:
  - When mem_rvalid: owner's rvalid=1 in the same cycle (combinational pass-through) and owner's rdata=mem_rdata.
  - err=0; state ← IDLE.
  - The non-owner's rvalid stays 0.
- WAIT, timeout:
  - When wait_cnt==TIMEOUT-1 and !mem_rvalid: owner's rvalid=1, err=1, rdata=0; state ← IDLE.
  - mem_rvalid and timeout in the same cycle: the response wins, err=0.
- Back-to-back: there is no grant in the cycle a response or timeout completes. Minimum grant-to-grant spacing is (memory latency + 1) cycles.
- Stray mem_rvalid in IDLE is ignored; no requester output is affected.
- A late response after a timeout falls in IDLE and is dropped.
- Reset mid-transaction: the in-flight transaction is abandoned with no rvalid to either requester. Requesters must re-issue.
- rdata of a non-owner, or outside rvalid, is driven 0.

Test Plan:
- Single fetch: if_req=1, addr=0x100, mem_ready=1, mem_rvalid 2 cycles after grant with rdata=0xDEADBEEF → if_gnt pulses in cycle 0; if_rvalid=1, if_rdata=0xDEADBEEF, if_err=0 in cycle 2; dm_* outputs stay 0.
- Simultaneous requests: if_req=dm_req=1, dm_we=1, dm_addr=0x200, wdata=0x12345678, be=0xF → dm_gnt first with mem_we=1 and matching fields; after dm_rvalid, IF is granted on the next IDLE cycle.
- Starvation: if_req held high, dm_req re-issued continuously, STARVE_LIMIT=4 → exactly 4 DM grants, then an IF grant, then DM wins again.
- Timeout: grant DM load, mem_rvalid never asserted, TIMEOUT=16 → dm_rvalid=1, dm_err=1, dm_rdata=0 exactly 16 cycles after grant; a later mem_rvalid produces no requester pulse.
- Backpressure: mem_ready=0 for 3 cycles with if_req=1 → no if_gnt, mem_req=1 held with stable mem_addr; dm_req rising in cycle 2 takes over mem_addr and receives the grant when mem_ready rises.
- Async reset: assert rst mid-WAIT, between clock edges → all outputs 0 immediately; after release, the FSM is in IDLE and the pending mem_rvalid is ignored.
